// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned SEL_W = 5;

  typedef enum logic [SEL_W-1:0] {
    OP_MUL    = 5'h1E,
    OP_MULH   = 5'h1F,
    OP_MULHU  = 5'h18,
    OP_MULHSU = 5'h19,
    OP_DIV    = 5'h12,
    OP_DIVU   = 5'h13,
    OP_REM    = 5'h14,
    OP_REMU   = 5'h15
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } muldiv_state_e;

  function automatic logic is_legal(input logic [SEL_W-1:0] sel);
    return sel inside {5'h1E, 5'h1F, 5'h18, 5'h19, 5'h12, 5'h13, 5'h14, 5'h15};
  endfunction

  function automatic logic is_mul(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU};
  endfunction

  function automatic logic is_high(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHU, OP_MULHSU};
  endfunction

  function automatic logic is_rem(input muldiv_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_a(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Valid/ready request and response bundle between the execute stage and the unit.
interface muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] dataA;
  logic [XLEN-1:0] dataB;
  logic [4:0]      sel;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] dataD;
  logic            out_err;

  modport master (
    output flush, in_valid, dataA, dataB, sel, out_ready,
    input  in_ready, out_valid, dataD, out_err
  );

  modport slave (
    input  flush, in_valid, dataA, dataB, sel, out_ready,
    output in_ready, out_valid, dataD, out_err
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and result signs.
module muldiv_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout_c
);
  assign dout_c = neg ? (~din + W'(1)) : din;
endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative M-extension multiply/divide with valid/ready on both sides,
// flush, illegal-select error and single-cycle early-out for special divides.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned W2    = 2 * XLEN;

  muldiv_state_e   st_q, st_d;
  muldiv_op_e      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic            out_valid_q, out_valid_d;
  logic            out_err_q, out_err_d;
  logic [XLEN-1:0] res_q, res_d;

  logic [XLEN-1:0] mag_a_c, mag_b_c;
  logic            neg_a_c, neg_b_c;
  logic [W2-1:0]   fix_in_c, fix_out_c;
  logic            fix_neg_c;

  logic            accept;
  logic            special;
  muldiv_op_e      sel_op;
  logic            b_zero, a_min, b_m1;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;

  assign neg_a_c = is_signed_a(op_q) & a_q[XLEN-1];
  assign neg_b_c = is_signed_b(op_q) & b_q[XLEN-1];

  muldiv_sign_fix #(.W(XLEN)) u_mag_a (.din(a_q), .neg(neg_a_c), .dout_c(mag_a_c));
  muldiv_sign_fix #(.W(XLEN)) u_mag_b (.din(b_q), .neg(neg_b_c), .dout_c(mag_b_c));

  // Result negation runs over the full double-width product so MULH* see the true high half.
  always_comb begin
    fix_in_c  = acc_q;
    fix_neg_c = sa_q ^ sb_q;
    if (is_rem(op_q)) begin
      fix_in_c  = {XLEN'(0), rem_q};
      fix_neg_c = sa_q;
    end else if (!is_mul(op_q)) begin
      fix_in_c  = {XLEN'(0), acc_q[XLEN-1:0]};
    end
  end

  muldiv_sign_fix #(.W(W2)) u_fix (.din(fix_in_c), .neg(fix_neg_c), .dout_c(fix_out_c));

  assign bus.in_ready  = (st_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.dataD     = res_q;
  assign bus.out_err   = out_err_q;

  always_comb begin
    st_d        = st_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    res_d       = res_q;
    special     = 1'b0;

    accept  = bus.in_valid & (st_q == ST_IDLE) & ~bus.flush;
    sel_op  = muldiv_op_e'(bus.sel);
    b_zero  = (bus.dataB == '0);
    a_min   = (bus.dataA == {1'b1, {(XLEN-1){1'b0}}});
    b_m1    = &bus.dataB;

    // Shift-add keeps the multiplier in the low half and the growing product in the high half.
    mul_sum   = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    // Restoring divide: dividend bits leave the low half MSB-first, quotient bits enter at the LSB.
    div_shift = {rem_q, acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};

    case (st_q)
      ST_IDLE: begin
        if (accept) begin
          a_d  = bus.dataA;
          b_d  = bus.dataB;
          op_d = sel_op;
          if (!is_legal(bus.sel)) begin
            special   = 1'b1;
            res_d     = '0;
            out_err_d = 1'b1;
            op_d      = op_q;
          end else if ((sel_op == OP_DIV || sel_op == OP_DIVU) && b_zero) begin
            special = 1'b1;
            res_d   = '1;
          end else if (is_rem(sel_op) && b_zero) begin
            special = 1'b1;
            res_d   = bus.dataA;
          end else if (sel_op == OP_DIV && a_min && b_m1) begin
            special = 1'b1;
            res_d   = bus.dataA;
          end else if (sel_op == OP_REM && a_min && b_m1) begin
            special = 1'b1;
            res_d   = '0;
          end
          if (special) begin
            st_d        = ST_DONE;
            out_valid_d = 1'b1;
          end else begin
            st_d      = ST_PREP;
            out_err_d = 1'b0;
          end
        end
      end
      ST_PREP: begin
        sa_d  = neg_a_c;
        sb_d  = neg_b_c;
        cnt_d = CNT_W'(XLEN - 1);
        if (is_mul(op_q)) begin
          a_d   = mag_a_c;
          acc_d = {XLEN'(0), mag_b_c};
        end else begin
          b_d   = mag_b_c;
          acc_d = {XLEN'(0), mag_a_c};
          rem_d = '0;
        end
        st_d = ST_CALC;
      end
      ST_CALC: begin
        if (is_mul(op_q)) begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
          rem_d = div_diff[XLEN-1:0];
          acc_d = {acc_q[W2-1:XLEN], acc_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = div_shift[XLEN-1:0];
          acc_d = {acc_q[W2-1:XLEN], acc_q[XLEN-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          st_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FIX: begin
        res_d       = is_high(op_q) ? fix_out_c[W2-1:XLEN] : fix_out_c[XLEN-1:0];
        out_err_d   = 1'b0;
        out_valid_d = 1'b1;
        st_d        = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
          st_d        = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase

    if (bus.flush) begin
      st_d        = ST_IDLE;
      out_valid_d = 1'b0;
      out_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= ST_IDLE;
      op_q        <= OP_MUL;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      res_q       <= '0;
    end else begin
      st_q        <= st_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      res_q       <= res_d;
    end
  end

endmodule
